// File: rtl/lru_single.sv
// rtl/lru_single.sv - per-way age update slice for an 8-way true-LRU replacement scheme
module lru_single #(
    parameter int WIDTH = 3,
    parameter int INDEX = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lru,
    input  logic [WIDTH-1:0] hitLRU,
    input  logic             init,
    input  logic             en,
    output logic [WIDTH-1:0] newLRU,
    output logic             newLRU_vld,
    output logic             victim
);

    localparam logic [WIDTH-1:0] INIT_AGE = WIDTH'(INDEX);

    logic [WIDTH-1:0] nxt;

    // Ways younger than the hitter age by one; the hitter becomes MRU; older ways hold.
    // The increment cannot wrap because lru < hitLRU <= all-ones.
    always_comb begin
        nxt = lru;
        if (init) begin
            nxt = INIT_AGE;
        end else if (!en) begin
            nxt = lru;
        end else if (lru == hitLRU) begin
            nxt = '0;
        end else if (lru < hitLRU) begin
            nxt = lru + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            newLRU     <= INIT_AGE;
            newLRU_vld <= 1'b0;
        end else begin
            newLRU     <= nxt;
            newLRU_vld <= en | init;
        end
    end

    assign victim = &lru;

endmodule

// File: tb/tb_lru_single.sv
// tb/tb_lru_single.sv - directed and permutation-sweep bench for lru_single
module tb_lru_single;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] lru, hit_lru;
    logic       init, en;
    logic [2:0] new_lru;
    logic       new_vld, victim;

    logic       s_rst, s_init, s_en;
    logic [2:0] s_hit;
    logic [2:0] s_lru [8];
    logic [2:0] s_new [8];
    logic       s_vld [8];
    logic       s_vic [8];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    lru_single #(.WIDTH(3), .INDEX(2)) u_dut (
        .clk(clk), .rst(rst), .lru(lru), .hitLRU(hit_lru), .init(init), .en(en),
        .newLRU(new_lru), .newLRU_vld(new_vld), .victim(victim)
    );

    for (genvar g = 0; g < 8; g++) begin : g_way
        lru_single #(.WIDTH(3), .INDEX(g)) u_way (
            .clk(clk), .rst(s_rst), .lru(s_lru[g]), .hitLRU(s_hit), .init(s_init), .en(s_en),
            .newLRU(s_new[g]), .newLRU_vld(s_vld[g]), .victim(s_vic[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic i, input logic e,
                         input logic [2:0] l, input logic [2:0] h);
        rst = r; init = i; en = e; lru = l; hit_lru = h;
    endtask

    logic [2:0]  model [8];
    logic [2:0]  expv  [8];
    logic [23:0] obs_vec, exp_vec;
    logic [7:0]  seen;
    int          hit_way;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        s_rst = 1'b0; s_init = 1'b0; s_en = 1'b0; s_hit = '0;
        for (int i = 0; i < 8; i++) s_lru[i] = '0;

        tick();
        check("reset_age", 32'(new_lru), 32'd2);
        check("reset_vld", 32'(new_vld), 32'd0);
        check("victim_age0", 32'(victim), 32'd0);

        drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        tick();
        check("init_age", 32'(new_lru), 32'd2);
        check("init_vld", 32'(new_vld), 32'd1);

        drive(1'b1, 1'b0, 1'b1, 3'd5, 3'd5);
        tick();
        check("hit_self_age", 32'(new_lru), 32'd0);
        check("hit_self_vld", 32'(new_vld), 32'd1);

        drive(1'b1, 1'b0, 1'b1, 3'd3, 3'd6);
        tick();
        check("aging_3_6", 32'(new_lru), 32'd4);

        drive(1'b1, 1'b0, 1'b1, 3'd6, 3'd7);
        #1;
        check("victim_lru6", 32'(victim), 32'd0);
        tick();
        check("aging_6_7", 32'(new_lru), 32'd7);

        drive(1'b1, 1'b0, 1'b0, 3'd7, 3'd0);
        #1;
        check("victim_lru7", 32'(victim), 32'd1);
        tick();
        check("hold_7_age", 32'(new_lru), 32'd7);
        check("hold_7_vld", 32'(new_vld), 32'd0);

        drive(1'b1, 1'b0, 1'b1, 3'd6, 3'd2);
        tick();
        check("older_unchanged", 32'(new_lru), 32'd6);

        drive(1'b1, 1'b0, 1'b1, 3'd4, 3'd0);
        tick();
        check("miss_lru4", 32'(new_lru), 32'd4);

        drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd0);
        tick();
        check("miss_lru0", 32'(new_lru), 32'd0);
        check("miss_lru0_vld", 32'(new_vld), 32'd1);

        drive(1'b1, 1'b0, 1'b0, 3'd1, 3'd5);
        tick();
        check("disabled_age", 32'(new_lru), 32'd1);
        check("disabled_vld", 32'(new_vld), 32'd0);

        drive(1'b1, 1'b1, 1'b1, 3'd5, 3'd5);
        tick();
        check("init_over_en_age", 32'(new_lru), 32'd2);
        check("init_over_en_vld", 32'(new_vld), 32'd1);

        drive(1'b1, 1'b0, 1'b1, 3'd5, 3'd5);
        tick();
        check("pre_reset_hit", 32'(new_lru), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 3'd3, 3'd6);
        tick();
        check("rst_over_init_age", 32'(new_lru), 32'd2);
        check("rst_over_init_vld", 32'(new_vld), 32'd0);

        // Permutation sweep across eight slices from a random starting permutation.
        for (int i = 0; i < 8; i++) model[i] = 3'(i);
        for (int i = 7; i > 0; i--) begin
            int j;
            logic [2:0] t;
            j = $urandom_range(i, 0);
            t = model[i]; model[i] = model[j]; model[j] = t;
        end
        tick();
        for (int i = 0; i < 8; i++) check("sweep_reset_age", 32'(s_new[i]), 32'(i));
        s_rst = 1'b1;
        s_en  = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            s_hit = 3'($urandom_range(7, 0));
            hit_way = -1;
            for (int i = 0; i < 8; i++) begin
                s_lru[i] = model[i];
                if (model[i] == s_hit) begin
                    expv[i] = 3'd0;
                    hit_way = i;
                end else if (model[i] < s_hit) begin
                    expv[i] = model[i] + 3'd1;
                end else begin
                    expv[i] = model[i];
                end
            end
            tick();
            seen = '0;
            for (int i = 0; i < 8; i++) begin
                obs_vec[i*3 +: 3] = s_new[i];
                exp_vec[i*3 +: 3] = expv[i];
                seen[s_new[i]] = 1'b1;
            end
            check("sweep_ages", 32'(obs_vec), 32'(exp_vec));
            check("sweep_permutation", 32'(seen), 32'hff);
            check("sweep_hitter_mru", (hit_way >= 0) ? 32'(s_new[hit_way]) : 32'hdead, 32'd0);
            for (int i = 0; i < 8; i++) model[i] = expv[i];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
